// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, defaults and helpers for the multi-port register file
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRD   = 2;

    function automatic int addr_width(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits with set-wins priority
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [NREGS-1:0] busy
);

    // Bit 0 stays constant zero; a set on the same register as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int i = 1; i < NREGS; i++) begin
                if (set_en && (set_addr == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (clr_en && (clr_addr == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with zero register, post-reset clear and busy scoreboard (optional REGFILE_BYPASS_EN forwarding)
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  XLEN  = DEF_XLEN,
    parameter int  NREGS = DEF_NREGS,
    parameter int  NRD   = DEF_NRD,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [XLEN-1:0]   wd,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              ready
);

    rf_state_e         state;
    logic [AW-1:0]     clr_cnt;
    logic              run;
    logic [XLEN-1:0]   mem [NREGS];
    logic              mem_we;
    logic [AW-1:0]     mem_wa;
    logic [XLEN-1:0]   mem_wd;
    logic [NREGS-1:0]  busy;
    logic              wb_hit;

    assign run    = (state == RUN);
    assign wb_hit = we && (wa != '0);

    // Clear sequence walks registers 1..NREGS-1; register 0 is never stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= AW'(1);
            ready   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + AW'(1);
                    if (clr_cnt == AW'(NREGS - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = wa;
        mem_wd = wd;
        if (!run) begin
            mem_we = 1'b1;
            mem_wa = clr_cnt;
            mem_wd = '0;
        end else if (wb_hit) begin
            mem_we = 1'b1;
        end
    end

    // No reset on the array so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (run && iss_valid && (iss_rd != '0)),
        .set_addr (iss_rd),
        .clr_en   (run && wb_hit),
        .clr_addr (wa),
        .busy     (busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] stored;

        assign addr   = rd_addr[k*AW +: AW];
        assign stored = (addr == '0) ? '0 : mem[addr];

`ifdef REGFILE_BYPASS_EN
        logic fwd;

        // A same-cycle reissue of the written register keeps the operand pending.
        assign fwd = wb_hit && (wa == addr);
        assign rd_data[k*XLEN +: XLEN] = !run ? '0 : (fwd ? wd : stored);
        assign rd_busy[k] = run && busy[addr] &&
                            !(fwd && !(iss_valid && (iss_rd == wa)));
`else
        assign rd_data[k*XLEN +: XLEN] = run ? stored : '0;
        assign rd_busy[k] = run && busy[addr];
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp with directed vectors
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        ready;
    logic [4:0]  a0, a1;

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  b;
        logic        rdy;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;

    assign rd_addr = {a1, a0};

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .ready     (ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string n, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] b, input logic rdy);
        exp_t x;
        x.name = n;
        x.d0   = d0;
        x.d1   = d1;
        x.b    = b;
        x.rdy  = rdy;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (rd_data !== {e.d1, e.d0} || rd_busy !== e.b || ready !== e.rdy) begin
                bad++;
                $display("FAIL %s: got data1=%h data0=%h busy=%b ready=%b, want data1=%h data0=%h busy=%b ready=%b",
                         e.name, rd_data[63:32], rd_data[31:0], rd_busy, ready, e.d1, e.d0, e.b, e.rdy);
            end
        end
    end

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; iss_valid = 1'b0; iss_rd = '0;
        a0 = '0; a1 = '0;
        step();
        step();
        expect_out("reset", 32'h0, 32'h0, 2'b00, 1'b0);

        rst = 1'b0;
        a0 = 5'd4; a1 = 5'd4;
        for (int i = 1; i <= 31; i++) begin
            step();
            we = (i == 3); wa = 5'd4; wd = 32'hFF;
            iss_valid = (i == 3); iss_rd = 5'd4;
            expect_out("clear", 32'h0, 32'h0, 2'b00, i == 31);
        end
        step();
        expect_out("init_ignored", 32'h0, 32'h0, 2'b00, 1'b1);

        for (int r = 0; r < 16; r++) begin
            step();
            a0 = 5'(2 * r); a1 = 5'(2 * r + 1);
            expect_out("sweep", 32'h0, 32'h0, 2'b00, 1'b1);
        end

        step();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; a0 = 5'd5; a1 = 5'd0;
`ifdef REGFILE_BYPASS_EN
        expect_out("wr5_same", 32'hDEADBEEF, 32'h0, 2'b00, 1'b1);
`else
        expect_out("wr5_same", 32'h0, 32'h0, 2'b00, 1'b1);
`endif
        step();
        we = 1'b1; wa = 5'd0; wd = 32'h1234;
        expect_out("wr0_same", 32'hDEADBEEF, 32'h0, 2'b00, 1'b1);
        step();
        we = 1'b0;
        expect_out("x0_read", 32'hDEADBEEF, 32'h0, 2'b00, 1'b1);

        step();
        iss_valid = 1'b1; iss_rd = 5'd7; a0 = 5'd7; a1 = 5'd5;
        expect_out("iss7_same", 32'h0, 32'hDEADBEEF, 2'b00, 1'b1);
        step();
        iss_valid = 1'b0;
        expect_out("busy7", 32'h0, 32'hDEADBEEF, 2'b01, 1'b1);
        step();
        expect_out("busy7_hold", 32'h0, 32'hDEADBEEF, 2'b01, 1'b1);
        step();
        we = 1'b1; wa = 5'd7; wd = 32'h77;
`ifdef REGFILE_BYPASS_EN
        expect_out("wb7_same", 32'h77, 32'hDEADBEEF, 2'b00, 1'b1);
`else
        expect_out("wb7_same", 32'h0, 32'hDEADBEEF, 2'b01, 1'b1);
`endif
        step();
        we = 1'b0;
        expect_out("wb7_after", 32'h77, 32'hDEADBEEF, 2'b00, 1'b1);

        step();
        iss_valid = 1'b1; iss_rd = 5'd3; a0 = 5'd3; a1 = 5'd7;
        expect_out("iss3", 32'h0, 32'h77, 2'b00, 1'b1);
        step();
        we = 1'b1; wa = 5'd3; wd = 32'h33;
`ifdef REGFILE_BYPASS_EN
        expect_out("setclr3_same", 32'h33, 32'h77, 2'b01, 1'b1);
`else
        expect_out("setclr3_same", 32'h0, 32'h77, 2'b01, 1'b1);
`endif
        step();
        we = 1'b0; iss_valid = 1'b0;
        expect_out("set_wins", 32'h33, 32'h77, 2'b01, 1'b1);
        step();
        we = 1'b1; wa = 5'd3; wd = 32'h34;
`ifdef REGFILE_BYPASS_EN
        expect_out("wb3_same", 32'h34, 32'h77, 2'b00, 1'b1);
`else
        expect_out("wb3_same", 32'h33, 32'h77, 2'b01, 1'b1);
`endif
        step();
        we = 1'b0;
        expect_out("wb3_after", 32'h34, 32'h77, 2'b00, 1'b1);

        step();
        we = 1'b1; wa = 5'd9; wd = 32'h11111111; a0 = 5'd0; a1 = 5'd9;
`ifdef REGFILE_BYPASS_EN
        expect_out("wr9_same", 32'h0, 32'h11111111, 2'b00, 1'b1);
`else
        expect_out("wr9_same", 32'h0, 32'h0, 2'b00, 1'b1);
`endif
        step();
        we = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9;
        expect_out("iss9", 32'h0, 32'h11111111, 2'b00, 1'b1);
        step();
        iss_valid = 1'b0; we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
        expect_out("bypass9", 32'h0, 32'hA5A5A5A5, 2'b00, 1'b1);
`else
        expect_out("bypass9", 32'h0, 32'h11111111, 2'b10, 1'b1);
`endif
        step();
        we = 1'b0;
        expect_out("wb9_after", 32'h0, 32'hA5A5A5A5, 2'b00, 1'b1);

        step();
        we = 1'b1; wa = 5'd12; wd = 32'hCAFE; iss_valid = 1'b1; iss_rd = 5'd0;
        a0 = 5'd12; a1 = 5'd0;
`ifdef REGFILE_BYPASS_EN
        expect_out("wr12_same", 32'hCAFE, 32'h0, 2'b00, 1'b1);
`else
        expect_out("wr12_same", 32'h0, 32'h0, 2'b00, 1'b1);
`endif
        step();
        we = 1'b0; iss_valid = 1'b0;
        expect_out("nonbusy_wb_x0_iss", 32'hCAFE, 32'h0, 2'b00, 1'b1);

        step();
        iss_valid = 1'b1; iss_rd = 5'd10; a0 = 5'd10; a1 = 5'd5;
        expect_out("iss10", 32'h0, 32'hDEADBEEF, 2'b00, 1'b1);
        step();
        iss_valid = 1'b0;
        expect_out("busy10", 32'h0, 32'hDEADBEEF, 2'b01, 1'b1);
        step();
        rst = 1'b1;
        #1;
        expect_out("rst_mid", 32'h0, 32'h0, 2'b00, 1'b0);
        step();
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            step();
            expect_out("clear2", 32'h0, 32'h0, 2'b00, i == 31);
        end
        step();
        expect_out("post_reset", 32'h0, 32'h0, 2'b00, 1'b1);

        step();
        step();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
